// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between IF and MEM, serialising 1/2/4-byte
// accesses into byte cycles and assembling little-endian read data.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_cancel,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_write,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic        owner_mem, owner_mem_nxt;
  logic [31:0] base, base_nxt;
  logic [31:0] wbuf, wbuf_nxt;
  logic [31:0] rbuf, rbuf_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [2:0]  nb, nb_nxt;
  logic        if_done_nxt, mem_done_nxt;
  logic [31:0] if_data_nxt, mem_rdata_nxt;
  logic [1:0]  cap_idx;
  logic        addressing;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_mem <= 1'b0;
      base      <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
      cnt       <= '0;
      nb        <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_data   <= '0;
      mem_rdata <= '0;
    end else begin
      state     <= state_nxt;
      owner_mem <= owner_mem_nxt;
      base      <= base_nxt;
      wbuf      <= wbuf_nxt;
      rbuf      <= rbuf_nxt;
      cnt       <= cnt_nxt;
      nb        <= nb_nxt;
      if_done   <= if_done_nxt;
      mem_done  <= mem_done_nxt;
      if_data   <= if_data_nxt;
      mem_rdata <= mem_rdata_nxt;
    end
  end

  // Byte arriving in read cycle cnt belongs to the address driven at cnt-1.
  assign cap_idx = cnt[1:0] - 2'd1;

  always_comb begin
    state_nxt     = state;
    owner_mem_nxt = owner_mem;
    base_nxt      = base;
    wbuf_nxt      = wbuf;
    rbuf_nxt      = rbuf;
    cnt_nxt       = cnt;
    nb_nxt        = nb;
    if_done_nxt   = 1'b0;
    mem_done_nxt  = 1'b0;
    if_data_nxt   = if_data;
    mem_rdata_nxt = mem_rdata;
    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        rbuf_nxt = '0;
        if (mem_req) begin
          owner_mem_nxt = 1'b1;
          base_nxt      = mem_addr;
          wbuf_nxt      = mem_wdata;
          case (mem_len)
            2'b00:   nb_nxt = 3'd1;
            2'b01:   nb_nxt = 3'd2;
            default: nb_nxt = 3'd4;
          endcase
          state_nxt = mem_write ? WRITE : READ;
        end else if (if_req && !if_cancel) begin
          owner_mem_nxt = 1'b0;
          base_nxt      = if_addr;
          nb_nxt        = 3'd4;
          state_nxt     = READ;
        end
      end
      READ: begin
        if (!owner_mem && if_cancel) begin
          state_nxt = IDLE;
        end else begin
          if (cnt != 3'd0) rbuf_nxt[{cap_idx, 3'b000} +: 8] = ram_din;
          if (cnt == nb) begin
            state_nxt = DONE;
            if (owner_mem) begin
              mem_done_nxt  = 1'b1;
              mem_rdata_nxt = rbuf_nxt;
            end else begin
              if_done_nxt = 1'b1;
              if_data_nxt = rbuf_nxt;
            end
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end
      WRITE: begin
        if (cnt == nb - 3'd1) begin
          state_nxt    = DONE;
          mem_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A store byte coinciding with reset must not reach the RAM.
  assign addressing = (state == READ && cnt != nb) || (state == WRITE);
  assign ram_wr     = (state == WRITE) && !rst;
  assign ram_a      = addressing ? base + {29'd0, cnt} : 32'd0;
  assign ram_dout   = ram_wr ? wbuf[{cnt[1:0], 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed table, arbitration/cancel/reset sequences and
// randomized traffic checked against a byte-array memory model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_cancel, if_done;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_write, mem_done;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  int total = 0;
  int bad   = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_write(mem_write), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  // RAM as seen by the DUT, and the bench's own expectation of its contents.
  logic [7:0] ram  [logic [31:0]];
  logic [7:0] gold [logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction
  function automatic logic [7:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : dflt(a);
  endfunction

  always @(posedge clk) begin
    ram_din <= ram_rd(ram_a);
    if (ram_wr) ram[ram_a] = ram_dout;
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]  = d;
    gold[a] = d;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input bit is_mem, input logic [1:0] len);
    if (!is_mem) return 4;
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] gold_load(input logic [31:0] a, input int n);
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < n; k++) d = d | ({24'd0, gold_rd(a + 32'(k))} << (8 * k));
    return d;
  endfunction

  // Called at a falling edge of an IDLE cycle; returns at the falling edge of the next IDLE cycle.
  task automatic run_txn(input bit is_mem, input bit wr, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input int exp_lat, input string nm);
    int n, lat;
    bit seq_ok, stray;
    logic [31:0] got, exp_a;
    logic        exp_wr;
    logic [7:0]  exp_d;
    n = nbytes(is_mem, len);
    if (is_mem) begin
      mem_req = 1'b1; mem_write = wr; mem_len = len; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    lat = 0; seq_ok = 1'b1; stray = 1'b0; got = '0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      exp_wr = 1'b0; exp_a = '0; exp_d = '0;
      if (c <= n) begin
        exp_a = addr + 32'(c - 1);
        if (is_mem && wr) begin
          exp_wr = 1'b1;
          exp_d  = 8'(wdata >> (8 * (c - 1)));
        end
      end
      if (ram_a !== exp_a || ram_wr !== exp_wr || ram_dout !== exp_d) seq_ok = 1'b0;
      if ((is_mem && if_done) || (!is_mem && mem_done)) stray = 1'b1;
      if (is_mem ? mem_done : if_done) begin
        lat = c;
        got = is_mem ? mem_rdata : if_data;
        mem_req = 1'b0; if_req = 1'b0;
      end else if (is_mem) begin
        mem_addr = $urandom; mem_wdata = $urandom;
        mem_len = 2'($urandom_range(3, 0)); mem_write = 1'($urandom_range(1, 0));
      end else begin
        if_addr = $urandom;
      end
    end
    mem_req = 1'b0; if_req = 1'b0;
    if (is_mem && wr)
      for (int k = 0; k < n; k++) gold[addr + 32'(k)] = 8'(wdata >> (8 * k));
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    if (!(is_mem && wr)) chk({nm, "_data"}, got, exp_data);
    chk({nm, "_ramseq"}, {31'd0, seq_ok}, 32'd1);
    chk({nm, "_stray_done"}, {31'd0, stray}, 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    bit          is_mem;
    bit          wr;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int cyc_m, cyc_i;
    logic [31:0] a6, a1, a4, a5, rd_m, rd_i;

    vecs[0]  = '{0, 0, 2'b10, 32'h0000_0100, 32'h0,         32'h0050_0013, 6};
    vecs[1]  = '{1, 1, 2'b00, 32'h0003_0004, 32'h0000_00AB, 32'h0,         2};
    vecs[2]  = '{1, 0, 2'b00, 32'h0003_0004, 32'h0,         32'h0000_00AB, 3};
    vecs[3]  = '{1, 1, 2'b01, 32'h0000_2101, 32'hDEAD_BEEF, 32'h0,         3};
    vecs[4]  = '{1, 0, 2'b10, 32'h0000_2100, 32'h0,         32'h44BE_EF11, 6};
    vecs[5]  = '{1, 0, 2'b01, 32'h0000_1FFF, 32'h0,         32'h0000_1234, 4};
    vecs[6]  = '{1, 1, 2'b10, 32'hFFFF_FFFE, 32'h8765_4321, 32'h0,         5};
    vecs[7]  = '{1, 0, 2'b10, 32'hFFFF_FFFE, 32'h0,         32'h8765_4321, 6};
    vecs[8]  = '{1, 0, 2'b11, 32'h0000_0100, 32'h0,         32'h0050_0013, 6};
    vecs[9]  = '{0, 0, 2'b10, 32'h0000_2100, 32'h0,         32'h44BE_EF11, 6};
    vecs[10] = '{1, 0, 2'b01, 32'h0000_2102, 32'h0,         32'h0000_44BE, 4};
    vecs[11] = '{1, 0, 2'b00, 32'hFFFF_FFFF, 32'h0,         32'h0000_0043, 3};

    preload(32'h100, 8'h13); preload(32'h101, 8'h00);
    preload(32'h102, 8'h50); preload(32'h103, 8'h00);
    preload(32'h2100, 8'h11); preload(32'h2103, 8'h44);
    preload(32'h1FFF, 8'h34); preload(32'h2000, 8'h12);
    preload(32'h30004, 8'h00);

    rst = 1'b1; if_req = 0; if_addr = 0; if_cancel = 0;
    mem_req = 0; mem_write = 0; mem_len = 0; mem_addr = 0; mem_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_flags", {29'd0, if_done, mem_done, ram_wr}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_txn(vecs[i].is_mem, vecs[i].wr, vecs[i].len, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_data, vecs[i].exp_lat, $sformatf("vec%0d", i));

    // MEM and IF request together: MEM first, IF right after DONE.
    if_req = 1; if_addr = 32'h100;
    mem_req = 1; mem_write = 0; mem_len = 2'b01; mem_addr = 32'h1FFF;
    cyc_m = 0; cyc_i = 0; a1 = 'x; a6 = 'x; rd_m = '0; rd_i = '0;
    for (int c = 1; c <= 16 && cyc_i == 0; c++) begin
      @(negedge clk);
      if (c == 1) a1 = ram_a;
      if (c == 6) a6 = ram_a;
      if (mem_done && cyc_m == 0) begin cyc_m = c; rd_m = mem_rdata; mem_req = 0; end
      if (if_done) begin cyc_i = c; rd_i = if_data; if_req = 0; end
    end
    if_req = 0; mem_req = 0;
    chk("arb_first_addr", a1, 32'h1FFF);
    chk("arb_mem_cycle", 32'(cyc_m), 32'd4);
    chk("arb_mem_data", rd_m, 32'h0000_1234);
    chk("arb_if_addr_c6", a6, 32'h100);
    chk("arb_if_cycle", 32'(cyc_i), 32'd11);
    chk("arb_if_data", rd_i, 32'h0050_0013);
    @(negedge clk);

    // Fetch cancelled in cycle 3; fresh fetch accepted in cycle 4.
    if_req = 1; if_addr = 32'h2100;
    cyc_i = 0; a4 = 'x; a5 = 'x; rd_i = '0;
    for (int c = 1; c <= 16 && cyc_i == 0; c++) begin
      @(negedge clk);
      if (if_done) begin cyc_i = c; rd_i = if_data; if_req = 0; end
      if (c == 3) if_cancel = 1;
      if (c == 4) begin a4 = ram_a; if_cancel = 0; if_addr = 32'h100; end
      if (c == 5) a5 = ram_a;
    end
    if_req = 0; if_cancel = 0;
    chk("cancel_idle_c4", a4, 32'd0);
    chk("cancel_new_addr_c5", a5, 32'h100);
    chk("cancel_done_cycle", 32'(cyc_i), 32'd10);
    chk("cancel_data", rd_i, 32'h0050_0013);
    @(negedge clk);

    // Reset in cycle 2 of a word store.
    for (int k = 0; k < 4; k++) preload(32'h3000 + 32'(k), 8'h00);
    mem_req = 1; mem_write = 1; mem_len = 2'b10; mem_addr = 32'h3000; mem_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1 chk("rst_store_wr_c2", {31'd0, ram_wr}, 32'd0);
    @(negedge clk);
    chk("rst_store_outs_c3", {29'd0, if_done, mem_done, ram_wr} | ram_a | {24'd0, ram_dout}
        | if_data | mem_rdata, 32'd0);
    rst = 0; mem_req = 0;
    cyc_m = 0;
    for (int c = 4; c <= 10; c++) begin
      @(negedge clk);
      if (mem_done) cyc_m = c;
    end
    chk("rst_store_no_done", 32'(cyc_m), 32'd0);
    chk("rst_store_byte0", {24'd0, ram_rd(32'h3000)}, 32'h0D);
    chk("rst_store_byte1", {24'd0, ram_rd(32'h3001)}, 32'h00);
    gold[32'h3000] = 8'h0D;

    // Randomized traffic against the byte-array model.
    for (int i = 0; i < 150; i++) begin
      int kind, n;
      bit is_mem, wr;
      logic [1:0]  len;
      logic [31:0] addr, wdata;
      kind  = $urandom_range(9, 0);
      is_mem = (kind < 7);
      wr     = (kind < 4);
      len    = 2'($urandom_range(3, 0));
      addr   = ($urandom_range(1, 0) == 1) ? 32'h8000 + 32'($urandom_range(255, 0))
                                          : 32'hFFFF_FFF8 + 32'($urandom_range(15, 0));
      wdata  = $urandom;
      n      = nbytes(is_mem, len);
      run_txn(is_mem, wr, len, addr, wdata, gold_load(addr, n),
              (is_mem && wr) ? n + 1 : n + 2, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
